fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, one in-flight synchronous imem request, registered output to decode.
// Define FETCH_SKID_EN to keep the in-flight response in a skid register across a stall (no bubble on release).
module fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [11:0] redirect_pc,
  output logic [11:0] address_imem,
  input  logic [31:0] q_imem,
  output logic [31:0] insn,
  output logic [11:0] insn_pc,
  output logic        insn_valid
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic        req_v_q, req_v_d;
  logic [11:0] req_pc_q, req_pc_d;
  logic [31:0] insn_q, insn_d;
  logic [11:0] insn_pc_q, insn_pc_d;
  logic        insn_valid_q, insn_valid_d;
`ifdef FETCH_SKID_EN
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_insn_q, skid_insn_d;
  logic [11:0] skid_pc_q, skid_pc_d;
`endif

  // A stall only matters while decode actually has something to hold.
  logic stall_hit;
  assign stall_hit = stall & insn_valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = ST_FILL;
    end else begin
      unique case (state_q)
        ST_FILL:  if (req_v_q)   state_d = ST_RUN;
        ST_RUN:   if (stall_hit) state_d = ST_STALL;
        ST_STALL: if (!stall)    state_d = ST_RUN;
        default:                 state_d = ST_FILL;
      endcase
    end
  end

  always_comb begin
    pc_d         = pc_q;
    req_v_d      = req_v_q;
    req_pc_d     = req_pc_q;
    insn_d       = insn_q;
    insn_pc_d    = insn_pc_q;
    insn_valid_d = insn_valid_q;
`ifdef FETCH_SKID_EN
    skid_v_d     = skid_v_q;
    skid_insn_d  = skid_insn_q;
    skid_pc_d    = skid_pc_q;
`endif
    if (redirect) begin
      pc_d         = redirect_pc;
      req_v_d      = 1'b0;
      insn_valid_d = 1'b0;
`ifdef FETCH_SKID_EN
      skid_v_d     = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_FILL, ST_RUN: begin
          if ((state_q == ST_RUN) && stall_hit) begin
            req_v_d = 1'b0;
`ifdef FETCH_SKID_EN
            skid_v_d    = req_v_q;
            skid_insn_d = q_imem;
            skid_pc_d   = req_pc_q;
`else
            // The response now arriving is dropped; rewind so it is fetched again.
            if (req_v_q) pc_d = req_pc_q;
`endif
          end else begin
            insn_valid_d = req_v_q;
            if (req_v_q) begin
              insn_d    = q_imem;
              insn_pc_d = req_pc_q;
            end
            req_v_d  = 1'b1;
            req_pc_d = pc_q;
            pc_d     = pc_q + 12'd1;
          end
        end
        ST_STALL: begin
          if (!stall) begin
`ifdef FETCH_SKID_EN
            insn_valid_d = skid_v_q;
            if (skid_v_q) begin
              insn_d    = skid_insn_q;
              insn_pc_d = skid_pc_q;
            end
            skid_v_d = 1'b0;
`else
            insn_valid_d = 1'b0;
`endif
            req_v_d  = 1'b1;
            req_pc_d = pc_q;
            pc_d     = pc_q + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      req_v_q      <= 1'b0;
      req_pc_q     <= '0;
      insn_q       <= '0;
      insn_pc_q    <= '0;
      insn_valid_q <= 1'b0;
`ifdef FETCH_SKID_EN
      skid_v_q     <= 1'b0;
      skid_insn_q  <= '0;
      skid_pc_q    <= '0;
`endif
    end else begin
      pc_q         <= pc_d;
      req_v_q      <= req_v_d;
      req_pc_q     <= req_pc_d;
      insn_q       <= insn_d;
      insn_pc_q    <= insn_pc_d;
      insn_valid_q <= insn_valid_d;
`ifdef FETCH_SKID_EN
      skid_v_q     <= skid_v_d;
      skid_insn_q  <= skid_insn_d;
      skid_pc_q    <= skid_pc_d;
`endif
    end
  end

  assign address_imem = pc_q;
  assign insn         = insn_q;
  assign insn_pc      = insn_pc_q;
  assign insn_valid   = insn_valid_q;

endmodule
